// File: rtl/life_ctrl.sv
// ---------------------------------------------------------------------------
// life_ctrl -- edit/step sequencer for the Life engine.
//
// Sits between the cap_touch key decoder and the life datapath. Key codes are
// turned into cursor moves, cell-flip strobes and generation-step requests,
// and completed generations are counted.
//
// Optional feature, enabled by defining LIFE_AUTORUN_EN:
//   auto-run scheduler (RUN_WAIT / RUN_STEP states, period counter,
//   stop_pending, running flag). When undefined, only EDIT and STEP exist,
//   key code 7 performs no action and running is tied low.
//
// Parameters:
//   X, Y        board width / height in cells
//   LOG2X/LOG2Y cursor widths (2**LOG2X >= X, 2**LOG2Y >= Y)
//   CNT_W       generation counter width
//   RUN_PERIOD  clocks from step_done to the next auto-run step_req (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   keys       in   3-bit key code (0 none,1 up,2 down,3 left,4 right,
//                   5 flip,6 next,7 run/stop)
//   step_done  in   one-cycle pulse: requested generation written back
//   step_req   out  level request for one generation, held until step_done
//   flip_stb   out  one-cycle strobe: invert cell at (cur_x, cur_y)
//   cur_x      out  cursor column
//   cur_y      out  cursor row
//   running    out  high while auto-run is active
//   gen_count  out  completed generations, wraps modulo 2**CNT_W
// ---------------------------------------------------------------------------
module life_ctrl #(
  parameter int X          = 16,
  parameter int Y          = 16,
  parameter int LOG2X      = 4,
  parameter int LOG2Y      = 4,
  parameter int CNT_W      = 16,
  parameter int RUN_PERIOD = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       keys,
  input  logic             step_done,
  output logic             step_req,
  output logic             flip_stb,
  output logic [LOG2X-1:0] cur_x,
  output logic [LOG2Y-1:0] cur_y,
  output logic             running,
  output logic [CNT_W-1:0] gen_count
);

  // Key codes
  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;
  localparam logic [2:0] KEY_FLIP  = 3'd5;
  localparam logic [2:0] KEY_NEXT  = 3'd6;
  localparam logic [2:0] KEY_RUN   = 3'd7;

  // Cursor limits and home position
  localparam logic [LOG2X-1:0] X_LAST = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_LAST = LOG2Y'(Y - 1);
  localparam logic [LOG2X-1:0] X_HOME = LOG2X'(X / 2);
  localparam logic [LOG2Y-1:0] Y_HOME = LOG2Y'(Y / 2);

`ifdef LIFE_AUTORUN_EN
  typedef enum logic [1:0] {EDIT, STEP, RUN_WAIT, RUN_STEP} state_e;

  // The counter counts RUN_PERIOD-1 down to 0, so clog2 bits are enough.
  localparam int              CW     = $clog2(RUN_PERIOD);
  localparam logic [CW-1:0]   RELOAD = CW'(RUN_PERIOD - 1);
`else
  typedef enum logic {EDIT, STEP} state_e;

  // Period parameter is referenced only in the auto-run build.
  localparam int unused_run_period = RUN_PERIOD;
`endif

  // -------------------------------------------------------------------------
  // Key path: two-stage register, then a registered event code. An event is
  // a nonzero code that differs from the previous sample, so a held key
  // yields one event and a direct change between codes yields a new one.
  // ev_q holds the event code for one cycle (KEY_NONE when no event).
  // -------------------------------------------------------------------------
  logic [2:0] k1_q;
  logic [2:0] k2_q;
  logic [2:0] ev_q;

  // NOTE: clocked state is written with non-blocking (<=) assignments so
  // every register samples the pre-edge values of the others; blocking
  // assignments here would collapse the k1 -> k2 pipeline into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      k1_q <= KEY_NONE;
      k2_q <= KEY_NONE;
      ev_q <= KEY_NONE;
    end else begin
      k1_q <= keys;
      k2_q <= k1_q;
      ev_q <= ((k1_q != KEY_NONE) && (k1_q != k2_q)) ? k1_q : KEY_NONE;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [LOG2X-1:0]  x_q, x_d;
  logic [LOG2Y-1:0]  y_q, y_d;
  logic              req_q, req_d;
  logic              flip_q, flip_d;
  logic [CNT_W-1:0]  gen_q, gen_d;

  // A step_done only counts while a request is outstanding; stray pulses
  // from the engine are ignored.
  logic step_ack;
  assign step_ack = step_done & req_q;

`ifdef LIFE_AUTORUN_EN
  logic              run_q, run_d;
  logic              stop_q, stop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_ev;

  assign run_ev = (ev_q == KEY_RUN);
`endif

  // Next-state and output logic
  // NOTE: every variable gets a default at the top of this block, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    req_d   = req_q;
    flip_d  = 1'b0;
    gen_d   = gen_q;
`ifdef LIFE_AUTORUN_EN
    run_d   = run_q;
    stop_d  = stop_q;
    cnt_d   = cnt_q;
`endif

    case (state_q)
      EDIT: begin
        case (ev_q)
          KEY_UP:    y_d = (y_q == '0)     ? Y_LAST : y_q - LOG2Y'(1);
          KEY_DOWN:  y_d = (y_q == Y_LAST) ? '0     : y_q + LOG2Y'(1);
          KEY_LEFT:  x_d = (x_q == '0)     ? X_LAST : x_q - LOG2X'(1);
          KEY_RIGHT: x_d = (x_q == X_LAST) ? '0     : x_q + LOG2X'(1);
          KEY_FLIP:  flip_d = 1'b1;
          KEY_NEXT: begin
            req_d   = 1'b1;
            state_d = STEP;
          end
          KEY_RUN: begin
`ifdef LIFE_AUTORUN_EN
            cnt_d   = RELOAD;
            run_d   = 1'b1;
            state_d = RUN_WAIT;
`endif
          end
          default: ;
        endcase
      end

      // Key events are dropped while a manual step is in flight.
      STEP: begin
        if (step_ack) begin
          req_d   = 1'b0;
          gen_d   = gen_q + CNT_W'(1);
          state_d = EDIT;
        end
      end

`ifdef LIFE_AUTORUN_EN
      // A stop request wins over the counter expiring in the same cycle.
      RUN_WAIT: begin
        if (run_ev) begin
          run_d   = 1'b0;
          state_d = EDIT;
        end else if (cnt_q == '0) begin
          req_d   = 1'b1;
          state_d = RUN_STEP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // A run event arriving with step_done in the same cycle still stops,
      // so the pending flag is combined with the live event here.
      RUN_STEP: begin
        if (step_ack) begin
          req_d = 1'b0;
          gen_d = gen_q + CNT_W'(1);
          if (stop_q | run_ev) begin
            run_d   = 1'b0;
            stop_d  = 1'b0;
            state_d = EDIT;
          end else begin
            cnt_d   = RELOAD;
            state_d = RUN_WAIT;
          end
        end else begin
          stop_d = stop_q | run_ev;
        end
      end
`endif

      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EDIT;
      x_q     <= X_HOME;
      y_q     <= Y_HOME;
      req_q   <= 1'b0;
      flip_q  <= 1'b0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      req_q   <= req_d;
      flip_q  <= flip_d;
      gen_q   <= gen_d;
    end
  end

`ifdef LIFE_AUTORUN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 1'b0;
      stop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      run_q  <= run_d;
      stop_q <= stop_d;
      cnt_q  <= cnt_d;
    end
  end

  assign running = run_q;
`else
  assign running = 1'b0;
`endif

  // All outputs come straight from registers.
  assign step_req  = req_q;
  assign flip_stb  = flip_q;
  assign cur_x     = x_q;
  assign cur_y     = y_q;
  assign gen_count = gen_q;

endmodule

// File: doc/life_ctrl.md
# life_ctrl

Edit/step sequencer for the Life engine. It sits between the cap_touch key decoder and the life datapath. It turns the 3-bit key code into cursor moves, cell-flip strobes and generation-step requests, and counts completed generations. An optional auto-run scheduler issues periodic step requests without key presses.

## Interface
- X, 16: board width in cells.
- Y, 16: board height in cells.
- LOG2X, 4: cursor x width; must satisfy 2^LOG2X >= X.
- LOG2Y, 4: cursor y width; must satisfy 2^LOG2Y >= Y.
- CNT_W, 16: generation counter width.
- RUN_PERIOD, 4096: clocks between auto-run steps, measured step_done to next step_req; must be >= 2.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- keys  in  3  key code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 flip, 6 next, 7 run/stop.
- step_done  in  1  one-cycle pulse from the engine when a requested generation has been written back.
- step_req  out  1  level request to compute one generation; held until step_done.
- flip_stb  out  1  one-cycle strobe: invert the cell at (cur_x, cur_y).
- cur_x  out  LOG2X  cursor column.
- cur_y  out  LOG2Y  cursor row.
- running  out  1  high while auto-run is active.
- gen_count  out  CNT_W  completed generations; wraps modulo 2^CNT_W.

## Operation
- Key path: keys registered into k1, then k1 into k2.
  - An event fires when k1 != 0 and k1 != k2.
  - Holding a key produces exactly one event; there is no auto-repeat.
  - Changing directly from one nonzero code to another produces a new event.
- States: EDIT, STEP, RUN_WAIT, RUN_STEP.
- EDIT:
  - up decrements cur_y; y=0 wraps to Y-1.
  - down increments cur_y; Y-1 wraps to 0.
  - left/right act on cur_x the same way, using X.
  - flip pulses flip_stb.
  - next asserts step_req and moves to STEP.
  - run moves to RUN_WAIT, loads the period counter with RUN_PERIOD-1, and sets running.
- STEP: every key event is dropped. On step_done: step_req drops, gen_count increments, state returns to EDIT.
- RUN_WAIT:
  - The period counter decrements every clock.
  - At 0: assert step_req and go to RUN_STEP.
  - A run event returns to EDIT and clears running.
  - All other keys are ignored.
- RUN_STEP:
  - A run event sets stop_pending.
  - On step_done: gen_count increments and step_req drops.
  - If stop_pending is set, go to EDIT, clear running and clear stop_pending.
  - Otherwise reload the counter and go to RUN_WAIT.
- step_done while step_req is low is ignored; it does not change gen_count or state.
- flip_stb is never asserted while step_req is high.

## Timing
- Reset values: state EDIT, cur_x = X/2, cur_y = Y/2, step_req 0, flip_stb 0, running 0, gen_count 0, k1 = k2 = 0, stop_pending 0.
- Key latency: keys changes before edge n. The event is decoded after edge n+1. Its effect (cur_x/cur_y update, flip_stb high, step_req high, running high) is visible after edge n+2.
- flip_stb is exactly one cycle wide.
- step_done high at edge m: step_req low, gen_count +1 and the new state are all visible after edge m.
- A key event and step_done in the same cycle: step_done is processed, and the key event is handled per the current (pre-transition) state rules. So in STEP it is dropped, and in RUN_STEP a run event still stops.
- Auto-run cadence: step_req rises exactly RUN_PERIOD clocks after the step_done edge.
- Reset mid-step: step_req drops on the reset edge and all state returns to reset values. The engine must tolerate an abandoned request.

## Configuration
- LIFE_AUTORUN_EN defined: RUN_WAIT/RUN_STEP, the period counter, stop_pending and running logic are built as described.
- LIFE_AUTORUN_EN undefined:
  - Only EDIT and STEP exist.
  - Key code 7 is ignored like code 0 for actions, but it still updates k1/k2.
  - running is tied to 0.
  - RUN_PERIOD is unused.

## Test plan
- Reset, then hold up for 10 clocks: cur_y goes 8 -> 7 exactly once, 2 clocks after keys change; cur_x stays 8.
- From reset, 9 left events, each separated by keys=0: cur_x steps 7,6,…,0, then wraps to 15.
- EDIT, flip event: flip_stb high for exactly one cycle, 2 clocks after keys change. Send next, then flip while step_req is high: no flip_stb. Pulse step_done: step_req falls, gen_count = 1.
- With LIFE_AUTORUN_EN, RUN_PERIOD=8, engine answering step_done 3 clocks after step_req: after a run event, step_req rises every 8 clocks after each done. Run pressed during a step gives exactly one more gen_count increment, then EDIT with running = 0.
- Stray step_done in EDIT: gen_count unchanged. gen_count preloaded to 0xFFFF plus one step: it wraps to 0.
- Assert reset while step_req is high in RUN_STEP: next cycle step_req = 0, running = 0, cursor (8,8), gen_count 0.
